// File: rtl/regfile_scheduler_pkg.sv
// rtl/regfile_scheduler_pkg.sv - shared register file constants and cycle-kind codes
package regfile_scheduler_pkg;

  localparam int NREGS     = 8;
  localparam int REG_SEL_W = $clog2(NREGS);
  localparam int BURST_W   = 4;

  typedef logic [1:0] rfs_kind_t;

  localparam rfs_kind_t RFS_IDLE  = 2'd0;
  localparam rfs_kind_t RFS_READ  = 2'd1;
  localparam rfs_kind_t RFS_WRITE = 2'd2;

endpackage

// File: rtl/regfile_scheduler_scoreboard.sv
// rtl/regfile_scheduler_scoreboard.sv - per-register busy scoreboard with two-selector hazard lookup
module rf_scoreboard #(
  parameter int NREGS = regfile_scheduler_pkg::NREGS,
  parameter int SEL_W = regfile_scheduler_pkg::REG_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set_en,
  input  logic [SEL_W-1:0] i_set_sel,
  input  logic             i_clr_a_en,
  input  logic [SEL_W-1:0] i_clr_a_sel,
  input  logic             i_clr_b_en,
  input  logic [SEL_W-1:0] i_clr_b_sel,
  input  logic [SEL_W-1:0] i_look_a_sel,
  input  logic [SEL_W-1:0] i_look_b_sel,
  output logic [NREGS-1:0] o_busy,
  output logic             o_hazard,
  output logic             o_err
);
  import regfile_scheduler_pkg::*;

  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  logic [NREGS-1:0] r_busy;
  logic             r_err;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic             w_clr_stray;

  assign w_set_mask  = i_set_en ? (ONE << i_set_sel) : '0;
  assign w_clr_mask  = (i_clr_a_en ? (ONE << i_clr_a_sel) : '0) |
                       (i_clr_b_en ? (ONE << i_clr_b_sel) : '0);
  // A writeback to a register nobody reserved means the pipeline lost track of it
  assign w_clr_stray = (i_clr_a_en && !r_busy[i_clr_a_sel]) ||
                       (i_clr_b_en && !r_busy[i_clr_b_sel]);

  assign o_busy   = r_busy;
  assign o_hazard = r_busy[i_look_a_sel] | r_busy[i_look_b_sel];
  assign o_err    = r_err;

  // Busy bits: reserve on issue, release on writeback; the two never target one bit together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy | w_set_mask) & ~w_clr_mask;
    end
  end

  // Sticky stray-writeback flag, only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_clr_stray) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scheduler.sv
// rtl/regfile_scheduler.sv - register file scheduler: issue/writeback arbitration with burst guard
module regfile_scheduler #(
  parameter int NREGS        = regfile_scheduler_pkg::NREGS,
  parameter int SEL_W        = regfile_scheduler_pkg::REG_SEL_W,
  parameter int DATA_W       = 16,
  parameter int MAX_WB_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [SEL_W-1:0]  iss_rd,
  input  logic [SEL_W-1:0]  iss_rs,
  input  logic              iss_wb,
  output logic              rd_valid,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_en,
  output logic              rf_wr_en,
  output logic              rf_rS_wr_en,
  output logic [SEL_W-1:0]  rf_rD_sel,
  output logic [SEL_W-1:0]  rf_rS_sel,
  output logic [DATA_W-1:0] rf_rD_din,
  output logic [DATA_W-1:0] rf_rS_din,
  output logic [NREGS-1:0]  busy,
  output logic              sb_err
);
  import regfile_scheduler_pkg::*;

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_WB_BURST);

  logic [BURST_W-1:0] r_burst;
  logic               r_rd_valid;
  rfs_kind_t          w_kind;
  logic               w_hazard;
  logic               w_iss_ok;
  logic               w_wb_req;
  logic               w_burst_full;
  logic               w_alu_go;
  logic               w_mem_go;
  logic               w_set_en;

  assign w_iss_ok     = iss_valid && !w_hazard;
  assign w_wb_req     = alu_valid || mem_valid;
  assign w_burst_full = (r_burst == BURST_MAX);

  // Choose the cycle kind; writebacks win unless the pending issue has waited out a full burst
  always_comb begin
    w_kind = RFS_IDLE;
    if (!rst_n) begin
      w_kind = RFS_IDLE;
    end else if (w_iss_ok && (!w_wb_req || w_burst_full)) begin
      w_kind = RFS_READ;
    end else if (w_wb_req) begin
      w_kind = RFS_WRITE;
    end
  end

  // On a shared destination the load lands first and the ALU result follows next cycle
  assign w_mem_go = (w_kind == RFS_WRITE) && mem_valid;
  assign w_alu_go = (w_kind == RFS_WRITE) && alu_valid && !(mem_valid && (mem_sel == alu_sel));
  assign w_set_en = (w_kind == RFS_READ) && iss_wb;

  assign iss_ready = (w_kind == RFS_READ);
  assign alu_ready = w_alu_go;
  assign mem_ready = w_mem_go;
  assign rd_valid  = r_rd_valid;

  // Drive the regfile ports: ALU owns rD, load owns rS, issue uses both as read selectors
  always_comb begin
    rf_en       = (w_kind != RFS_IDLE);
    rf_wr_en    = w_alu_go;
    rf_rS_wr_en = w_mem_go;
    rf_rD_sel   = '0;
    rf_rS_sel   = '0;
    rf_rD_din   = '0;
    rf_rS_din   = '0;
    if (w_kind == RFS_READ) begin
      rf_rD_sel = iss_rd;
      rf_rS_sel = iss_rs;
    end
    if (w_alu_go) begin
      rf_rD_sel = alu_sel;
      rf_rD_din = alu_data;
    end
    if (w_mem_go) begin
      rf_rS_sel = mem_sel;
      rf_rS_din = mem_data;
    end
  end

  // Count writeback cycles that keep a waiting issue out, saturating at the burst limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else if ((w_kind == RFS_READ) || !iss_valid) begin
      r_burst <= '0;
    end else if ((w_kind == RFS_WRITE) && !w_burst_full) begin
      r_burst <= r_burst + 1'b1;
    end
  end

  // Operand data appears one cycle after the read is issued to the regfile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (w_kind == RFS_READ);
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .SEL_W (SEL_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_set_en     (w_set_en),
    .i_set_sel    (iss_rd),
    .i_clr_a_en   (w_alu_go),
    .i_clr_a_sel  (alu_sel),
    .i_clr_b_en   (w_mem_go),
    .i_clr_b_sel  (mem_sel),
    .i_look_a_sel (iss_rd),
    .i_look_b_sel (iss_rs),
    .o_busy       (busy),
    .o_hazard     (w_hazard),
    .o_err        (sb_err)
  );

endmodule
